hex_display_arbiter: RTL and testbench
======================================

Name: hex_display_arbiter

Overview:
- Shares the six 7-segment digits HEX5..HEX0 among NUM_REQ requesters. Each requester supplies a 24-bit value, shown as six hex digits.
- Round-robin arbitration. The winner owns the display for HOLD_CYCLES clocks, or less if it releases early. Blank display when idle.
- Sits between client logic (switch readers, counters, debug taps) and the board HEX outputs.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 50000000, display ownership time in clocks (>=1); counter width is clog2(HOLD_CYCLES+1).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  NUM_REQ  per-requester display request; level-sensitive.
- data  input  24*NUM_REQ  requester i value in data[24*i+23:24*i]; nibble k drives HEXk.
- grant  output  NUM_REQ  one-hot owner indication, registered; all zero when no owner.
- HEX0, HEX1, HEX2, HEX3, HEX4, HEX5  output  8 each  active-low segments; bit7 = decimal point, bits6..0 = g..a.

Behaviour:
- Reset values: grant=0; HEX0..HEX5=8'hFF (all off); state=IDLE; rr pointer=0; hold counter=0.
- Digit encoding, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - DP bit7=1 (off) unless OPTIONAL feature is active.
- States: IDLE, HOLD, RELEASE.
- IDLE:
  - If any req is high, pick the first set req at or after the rr pointer, wrapping modulo NUM_REQ.
  - Next cycle: state=HOLD, grant=onehot(winner), HEX registers load the encoded winner data, counter=1, rr pointer=winner+1 (wraps to 0).
  - No req: remain in IDLE with HEX blank.
- HOLD:
  - grant stays high. HEX shows the value latched at grant; later data changes are ignored.
  - Counter increments each cycle.
  - When counter==HOLD_CYCLES, or req[owner] is sampled low, go to RELEASE next cycle.
- RELEASE:
  - grant=0. HEX keeps the last value for this one cycle. Next cycle: IDLE.
- On entering IDLE, HEX registers blank to 8'hFF.
- Latency:
  - req to grant/HEX update is 1 cycle from IDLE.
  - Back-to-back owners are separated by 2 grant-low cycles (RELEASE, IDLE).
- Simultaneous requests are resolved by rr pointer only; no fixed priority after reset (pointer=0 means req[0] wins first).
- A req raised during another owner's HOLD waits; it is never lost while held high.
- A req dropped before being granted is simply not considered.
- HOLD_CYCLES=1: exactly one HOLD cycle per grant.
- Reset asserted mid-HOLD: grant and HEX go to reset values asynchronously; pointer returns to 0.
- data bits of non-owners are don't-care. grant is never multi-hot.

Optional Feature:
- Macro: HEX_ARB_OWNER_DP_EN.
- Defined: while in HOLD, the decimal point of HEXi (i = owner index, i<6) is lit (bit7=0). All other DPs stay off. With NUM_REQ>6, owners 6+ light no DP.
- Undefined: every DP bit is 1 at all times; logic is absent.

Test Plan (HOLD_CYCLES=4, NUM_REQ=3):
- Reset, then req=3'b001, data0=24'h012345 -> after 1 cycle grant=001 and HEX5..HEX0=C0,F9,A4,B0,99,92. Grant lasts 4 cycles, then RELEASE, then HEX=FF.
- req=3'b111 held -> grants in order 001, 010, 100, 001. Each lasts 4 cycles, with 2 grant-low cycles between.
- Owner 1 drops req after 2 HOLD cycles -> grant falls 1 cycle later; next owner is 2 if requesting.
- During HOLD, owner changes data from 24'hAAAAAA to 24'h555555 -> HEX stays at 88 on all digits until release.
- Assert reset in the middle of HOLD -> same-cycle grant=0 and HEX=FF. After deassert with req=3'b110, req[1] wins (pointer reset).
- HEX_ARB_OWNER_DP_EN defined, owner 2, data 24'h000000 -> HEX2=40, other digits C0. Macro undefined -> all C0.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin sharing of the six board 7-segment digits
// (HEX5..HEX0) among NUM_REQ requesters. The winner's 24-bit value is latched
// at grant time and shown as six hex digits for up to HOLD_CYCLES clocks.
// Handshake: req[i] is a level request; grant[i] is the registered one-hot
// answer. A requester owns the display while grant[i] is high and gives it up
// early by dropping req[i]. After every ownership the grant stays low for two
// cycles (RELEASE, IDLE) before the next winner is chosen.
// Optional build macro: HEX_ARB_OWNER_DP_EN lights the decimal point of HEXi
// while owner i (i < 6) holds the display.
module hex_display_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [24*NUM_REQ-1:0]  data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             HEX0,
    output logic [7:0]             HEX1,
    output logic [7:0]             HEX2,
    output logic [7:0]             HEX3,
    output logic [7:0]             HEX4,
    output logic [7:0]             HEX5
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // state is kept as a plainly named signal so checkers can bind to it
    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;
    logic             found;
    logic [CNT_W-1:0] hold_cnt;
    logic [23:0]      win_data;
    logic             owner_req;
    logic [6:0]       seg [6];
    logic [5:0]       dp_n;

    // Active-low g..a pattern for one hex nibble
    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0: encode = 7'h40;
            4'h1: encode = 7'h79;
            4'h2: encode = 7'h24;
            4'h3: encode = 7'h30;
            4'h4: encode = 7'h19;
            4'h5: encode = 7'h12;
            4'h6: encode = 7'h02;
            4'h7: encode = 7'h78;
            4'h8: encode = 7'h00;
            4'h9: encode = 7'h10;
            4'hA: encode = 7'h08;
            4'hB: encode = 7'h03;
            4'hC: encode = 7'h46;
            4'hD: encode = 7'h21;
            4'hE: encode = 7'h06;
            default: encode = 7'h0E;
        endcase
    endfunction

    // Round-robin pick: first request at or above rr_ptr, else wrap to the lowest one
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) < rr_ptr)) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        next_ptr = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // Select the winner's value and the current owner's request level
    always_comb begin
        win_data  = '0;
        owner_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) win_data = data[24*i +: 24];
            if (owner == IDX_W'(i))  owner_req = req[i];
        end
    end

    // Ownership FSM with grant, hold counter and latched segment registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            for (int k = 0; k < 6; k++) seg[k] <= 7'h7F;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state    <= ST_HOLD;
                        grant    <= NUM_REQ'(1) << winner;
                        owner    <= winner;
                        rr_ptr   <= next_ptr;
                        hold_cnt <= CNT_W'(1);
                        for (int k = 0; k < 6; k++) seg[k] <= encode(win_data[4*k +: 4]);
                    end
                end
                ST_HOLD: begin
                    if ((hold_cnt == CNT_W'(HOLD_CYCLES)) || !owner_req) begin
                        state <= ST_RELEASE;
                        grant <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // digits keep the last value for this cycle, blank on entering IDLE
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    for (int k = 0; k < 6; k++) seg[k] <= 7'h7F;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef HEX_ARB_OWNER_DP_EN
    // Light the decimal point on the digit matching the owner index while holding
    always_comb begin
        dp_n = 6'h3F;
        if (state == ST_HOLD) begin
            for (int i = 0; i < 6; i++) begin
                if (int'(owner) == i) dp_n[i] = 1'b0;
            end
        end
    end
`else
    assign dp_n = 6'h3F;
`endif

    assign HEX0 = {dp_n[0], seg[0]};
    assign HEX1 = {dp_n[1], seg[1]};
    assign HEX2 = {dp_n[2], seg[2]};
    assign HEX3 = {dp_n[3], seg[3]};
    assign HEX4 = {dp_n[4], seg[4]};
    assign HEX5 = {dp_n[5], seg[5]};

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: scoreboard bench for hex_display_arbiter with
// NUM_REQ=3, HOLD_CYCLES=4. A reference model steps once per clock on the
// sampled inputs and queues the expected grant/HEX values; a monitor on the
// falling edge pops and compares against the DUT.
module tb_hex_display_arbiter;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int W    = N + 48;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req;
    logic [24*N-1:0] data;
    logic [N-1:0]    grant;
    logic [7:0]      HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [W-1:0] exp_q[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    hex_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD)) dut (
        .clock(clock), .reset(reset), .req(req), .data(data), .grant(grant),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    // clock / reset block
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // m_owner: index owning the display (-1 none); m_held: clocks owned so far;
    // m_gap: set right after an ownership ends, the one cycle the old digits linger.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_gap   = 0;
    int         m_ptr   = 0;
    int         m_cand;
    logic [7:0] m_hex [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [W-1:0] m_exp;
    logic [7:0]   m_out;

    always @(posedge clock) begin
        cycle++;
        if (reset) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0;
            for (int d = 0; d < 6; d++) m_hex[d] = 8'hFF;
        end else begin
            if (m_owner >= 0) begin
                if (m_held >= HOLD || !req[m_owner]) begin
                    m_owner = -1;
                    m_gap   = 1;
                end else begin
                    m_held++;
                end
            end else if (m_gap > 0) begin
                m_gap = 0;
                for (int d = 0; d < 6; d++) m_hex[d] = 8'hFF;
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    m_cand = (m_ptr + k) % N;
                    if (m_owner < 0 && req[m_cand]) m_owner = m_cand;
                end
                m_held = 1;
                m_ptr  = (m_owner + 1) % N;
                for (int d = 0; d < 6; d++) m_hex[d] = seg_tab[data[24*m_owner + 4*d +: 4]];
            end
            m_exp = '0;
            if (m_owner >= 0) m_exp[W-1 -: N] = N'(1 << m_owner);
            for (int d = 0; d < 6; d++) begin
                m_out = m_hex[d];
`ifdef HEX_ARB_OWNER_DP_EN
                if (m_owner == d) m_out[7] = 1'b0;
`endif
                m_exp[8*d +: 8] = m_out;
            end
            exp_q.push_back(m_exp);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] mon_exp;
    logic [7:0]   mon_hex [6];

    always @(negedge clock) begin
        if (!reset) begin
            mon_hex = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty cycle=%0d got=none required=entry", cycle);
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (grant !== mon_exp[W-1 -: N]) begin
                    failures++;
                    $display("FAIL grant cycle=%0d got=%b required=%b", cycle, grant, mon_exp[W-1 -: N]);
                end
                for (int d = 0; d < 6; d++) begin
                    checks++;
                    if (mon_hex[d] !== mon_exp[8*d +: 8]) begin
                        failures++;
                        $display("FAIL HEX%0d cycle=%0d got=%h required=%h", d, cycle, mon_hex[d], mon_exp[8*d +: 8]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_data(input int i, input logic [23:0] v);
        data[24*i +: 24] = v;
    endtask

    // direct check of the all-off reset outputs
    task automatic check_blank(input string name);
        logic [7:0] h [6];
        h = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
        checks++;
        if (grant !== '0) begin
            failures++;
            $display("FAIL %s_grant got=%b required=%b", name, grant, {N{1'b0}});
        end
        for (int d = 0; d < 6; d++) begin
            checks++;
            if (h[d] !== 8'hFF) begin
                failures++;
                $display("FAIL %s_HEX%0d got=%h required=ff", name, d, h[d]);
            end
        end
    endtask

    // async reset in the middle of an ownership, then release with req=110
    task automatic reset_mid_hold();
        @(posedge clock);
        #3;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_blank("reset_async");
        req = 3'b110;
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        req  = '0;
        data = '0;
        step(2);
        check_blank("reset_state");
        @(negedge clock);
        #1;
        reset = 1'b0;
        step(1);

        // single requester with a known value, then back to idle
        set_data(0, 24'h012345);
        req = 3'b001;
        step(7);
        req = 3'b000;
        step(4);

        // all requesting: rotation 0,1,2,0...
        set_data(1, 24'hABCDEF);
        set_data(2, 24'h9876FE);
        req = 3'b111;
        step(26);
        req = 3'b000;
        step(4);

        // owner 1 drops early, owner 2 waiting
        req = 3'b010;
        step(3);
        req = 3'b110;
        step(1);
        req = 3'b100;
        step(8);
        req = 3'b000;
        step(4);

        // data changes during ownership are ignored
        set_data(0, 24'hAAAAAA);
        req = 3'b001;
        step(2);
        set_data(0, 24'h555555);
        step(5);
        req = 3'b000;
        step(4);

        // owner 2 with all-zero data (decimal point case)
        set_data(2, 24'h000000);
        req = 3'b100;
        step(6);
        req = 3'b000;
        step(4);

        // reset during ownership, pointer must restart at 0
        req = 3'b001;
        step(2);
        reset_mid_hold();
        step(8);

        // randomized requests and data
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 2) == 0) set_data(i, 24'($urandom));
            end
            if (c == 700) reset_mid_hold();
            step(1);
        end
        req = '0;
        step(8);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
